// File: rtl/time_count_ctrl.sv
// MM:SS stopwatch controller: IDLE/RUN/PAUSE FSM, one-second prescaler and
// a four-digit BCD time register. Every output comes straight from a flop.
module time_count_ctrl #(
  parameter int TICK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_stop,
  input  logic       clear,
  output logic [3:0] seg_a_val,
  output logic [3:0] seg_b_val,
  output logic [3:0] seg_c_val,
  output logic [3:0] seg_d_val,
  output logic       running,
  output logic       rollover,
  output logic [1:0] state_dbg
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [PW-1:0] presc;
  logic          tick;
  logic          wrap;
  logic [3:0]    a_next;
  logic [3:0]    b_next;
  logic [3:0]    c_next;
  logic [3:0]    d_next;

  assign state_dbg = state;

  // CLEAR has priority over START_STOP; a held pulse acts every cycle.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = IDLE;
    end else if (start_stop) begin
      case (state)
        IDLE:    state_next = RUN;
        RUN:     state_next = PAUSE;
        PAUSE:   state_next = RUN;
        default: state_next = IDLE;
      endcase
    end
  end

  assign tick = (state == RUN) && (presc == PRESC_LAST);
  assign wrap = (seg_a_val == 4'd5) && (seg_b_val == 4'd9) &&
                (seg_c_val == 4'd5) && (seg_d_val == 4'd9);

  // Ripple BCD carry D -> C -> B -> A, seconds tens and minutes tens stop at 5.
  always_comb begin
    a_next = seg_a_val;
    b_next = seg_b_val;
    c_next = seg_c_val;
    d_next = seg_d_val;
    if (seg_d_val == 4'd9) begin
      d_next = 4'd0;
      if (seg_c_val == 4'd5) begin
        c_next = 4'd0;
        if (seg_b_val == 4'd9) begin
          b_next = 4'd0;
          a_next = (seg_a_val == 4'd5) ? 4'd0 : seg_a_val + 4'd1;
        end else begin
          b_next = seg_b_val + 4'd1;
        end
      end else begin
        c_next = seg_c_val + 4'd1;
      end
    end else begin
      d_next = seg_d_val + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      presc     <= '0;
      seg_a_val <= 4'd0;
      seg_b_val <= 4'd0;
      seg_c_val <= 4'd0;
      seg_d_val <= 4'd0;
      running   <= 1'b0;
      rollover  <= 1'b0;
    end else begin
      state   <= state_next;
      running <= (state_next == RUN);
      if (clear) begin
        presc     <= '0;
        seg_a_val <= 4'd0;
        seg_b_val <= 4'd0;
        seg_c_val <= 4'd0;
        seg_d_val <= 4'd0;
        rollover  <= 1'b0;
      end else begin
        rollover <= tick && wrap;
        // The tick still lands when START_STOP pauses on the same edge.
        if (state == RUN) begin
          presc <= tick ? '0 : presc + PW'(1);
        end
        if (tick) begin
          seg_a_val <= a_next;
          seg_b_val <= b_next;
          seg_c_val <= c_next;
          seg_d_val <= d_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_time_count_ctrl.sv
// Bench for time_count_ctrl with TICK_DIV = 4: an elapsed-seconds model checked
// every cycle, plus directed scenarios with literal expected times.
module tb_time_count_ctrl;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_stop = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] seg_a_val, seg_b_val, seg_c_val, seg_d_val;
  logic       running, rollover;
  logic [1:0] state_dbg;

  int checks = 0;
  int failures = 0;

  // model: 0 = stopped at zero, 1 = running, 2 = paused
  int   m_mode = 0;
  int   m_presc = 0;
  int   m_secs = 0;
  logic m_roll = 1'b0;

  time_count_ctrl #(.TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .start_stop(start_stop), .clear(clear),
    .seg_a_val(seg_a_val), .seg_b_val(seg_b_val),
    .seg_c_val(seg_c_val), .seg_d_val(seg_d_val),
    .running(running), .rollover(rollover), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int s);
    logic [3:0] a, b, c, d;
    a = 4'((s / 60) / 10);
    b = 4'((s / 60) % 10);
    c = 4'((s % 60) / 10);
    d = 4'((s % 60) % 10);
    return {a, b, c, d};
  endfunction

  function automatic logic [15:0] digits();
    return {seg_a_val, seg_b_val, seg_c_val, seg_d_val};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: elapsed seconds modulo one hour
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_mode  <= 0;
      m_presc <= 0;
      m_secs  <= 0;
      m_roll  <= 1'b0;
    end else if (clear) begin
      m_mode  <= 0;
      m_presc <= 0;
      m_secs  <= 0;
      m_roll  <= 1'b0;
    end else begin
      m_roll <= 1'b0;
      if (m_mode == 1) begin
        if (m_presc == TD - 1) begin
          m_presc <= 0;
          m_secs  <= (m_secs + 1) % 3600;
          m_roll  <= (m_secs == 3599);
        end else begin
          m_presc <= m_presc + 1;
        end
      end
      if (start_stop) m_mode <= (m_mode == 1) ? 2 : 1;
    end
  end

  // scoreboard compare on the falling edge
  always @(negedge clk) begin
    check("model_digits", {16'h0, digits()}, {16'h0, to_bcd(m_secs)});
    check("model_running", {31'h0, running}, {31'h0, (m_mode == 1)});
    check("model_rollover", {31'h0, rollover}, {31'h0, m_roll});
    check("bcd_legal", {31'h0, (seg_a_val <= 5 && seg_b_val <= 9 &&
                               seg_c_val <= 5 && seg_d_val <= 9)}, 32'h1);
  end

  // driver tasks: inputs change 1 time unit after a rising edge
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_ss();
    start_stop = 1'b1;
    step(1);
    start_stop = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    step(1);
    clear = 1'b0;
  endtask

  task automatic random_phase(input int n);
    for (int i = 0; i < n; i++) begin
      start_stop = ($urandom_range(0, 11) == 0);
      clear      = ($urandom_range(0, 59) == 0);
      step(1);
    end
    start_stop = 1'b0;
    clear = 1'b0;
  endtask

  initial begin
    step(3);
    check("reset_digits", {16'h0, digits()}, 32'h0);
    check("reset_running", {31'h0, running}, 32'h0);
    rst = 1'b0;
    step(2);

    // start and count
    pulse_ss();
    check("start_running", {31'h0, running}, 32'h1);
    step(3);
    check("start_no_inc_yet", {16'h0, digits()}, 32'h0000);
    step(1);
    check("start_0001", {16'h0, digits()}, 32'h0001);
    step(4);
    check("start_0002", {16'h0, digits()}, 32'h0002);

    // pause with prescaler at 2, resume
    step(1);
    pulse_ss();
    check("pause_running", {31'h0, running}, 32'h0);
    step(20);
    check("pause_held", {16'h0, digits()}, 32'h0002);
    pulse_ss();
    check("resume_running", {31'h0, running}, 32'h1);
    step(1);
    check("resume_not_yet", {16'h0, digits()}, 32'h0002);
    step(1);
    check("resume_0003", {16'h0, digits()}, 32'h0003);

    random_phase(400);

    // carry chain from 00:00
    pulse_clear();
    pulse_ss();
    for (int k = 1; k <= 600; k++) begin
      step(TD);
      if (k == 9)   check("carry_0009", {16'h0, digits()}, 32'h0009);
      if (k == 10)  check("carry_0010", {16'h0, digits()}, 32'h0010);
      if (k == 59)  check("carry_0059", {16'h0, digits()}, 32'h0059);
      if (k == 60)  check("carry_0100", {16'h0, digits()}, 32'h0100);
      if (k == 599) check("carry_0959", {16'h0, digits()}, 32'h0959);
      if (k == 600) check("carry_1000", {16'h0, digits()}, 32'h1000);
    end

    // rollover
    step(TD * 2999);
    check("roll_5959", {16'h0, digits()}, 32'h5959);
    step(TD - 1);
    check("roll_not_yet", {31'h0, rollover}, 32'h0);
    step(1);
    check("roll_0000", {16'h0, digits()}, 32'h0000);
    check("roll_pulse", {31'h0, rollover}, 32'h1);
    check("roll_running", {31'h0, running}, 32'h1);
    step(1);
    check("roll_pulse_end", {31'h0, rollover}, 32'h0);

    // CLEAR with START_STOP
    start_stop = 1'b1;
    clear = 1'b1;
    step(1);
    start_stop = 1'b0;
    clear = 1'b0;
    check("both_running", {31'h0, running}, 32'h0);
    check("both_digits", {16'h0, digits()}, 32'h0);

    // CLEAR on tick edge at 12:34
    pulse_ss();
    step(TD * 755 - 1);
    check("clr_tick_pre", {16'h0, digits()}, 32'h1234);
    pulse_clear();
    check("clr_tick_digits", {16'h0, digits()}, 32'h0000);
    check("clr_tick_running", {31'h0, running}, 32'h0);
    check("clr_tick_roll", {31'h0, rollover}, 32'h0);

    // START_STOP on tick edge at 12:34
    pulse_ss();
    step(TD * 755 - 1);
    check("ss_tick_pre", {16'h0, digits()}, 32'h1234);
    pulse_ss();
    check("ss_tick_digits", {16'h0, digits()}, 32'h1235);
    check("ss_tick_running", {31'h0, running}, 32'h0);

    // asynchronous reset mid-run at 03:07
    pulse_clear();
    pulse_ss();
    step(TD * 187 + 1);
    check("arst_pre", {16'h0, digits()}, 32'h0307);
    #2 rst = 1'b1;
    #1;
    check("arst_digits", {16'h0, digits()}, 32'h0);
    check("arst_running", {31'h0, running}, 32'h0);
    step(2);
    rst = 1'b0;
    step(12);
    check("arst_stays_idle", {16'h0, digits()}, 32'h0);
    check("arst_idle_running", {31'h0, running}, 32'h0);
    pulse_ss();
    check("arst_restart", {31'h0, running}, 32'h1);

    random_phase(600);
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
